// File: rtl/audio_in_pkg.sv
// Shared types and helpers for the audio-in level detector.
// Contents: FSM state encoding, saturated-magnitude ceiling helper.
package audio_in_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        UPDATE = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Largest positive two's-complement value for a given sample width.
    function automatic logic [63:0] mag_max(input int unsigned data_w);
        return (64'd1 << (data_w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/audio_in_mag.sv
// Combinational stereo magnitude: max(|left|, |right|), where the most
// negative code saturates to the largest positive code.
// Ports:
//   left, right : signed samples, DATA_W bits
//   mag_c       : unsigned magnitude, DATA_W bits (combinational)
module audio_in_mag
    import audio_in_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] left,
    input  logic [DATA_W-1:0] right,
    output logic [DATA_W-1:0] mag_c
);

    localparam logic [DATA_W-1:0] MAG_CEIL = DATA_W'(mag_max(DATA_W));
    localparam logic [DATA_W-1:0] NEG_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    // |x| with -2**(DATA_W-1) clamped, since its negation is not representable.
    function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] x);
        if (x == NEG_MIN)
            return MAG_CEIL;
        else if (x[DATA_W-1])
            return -x;
        else
            return x;
    endfunction

    logic [DATA_W-1:0] abs_l;
    logic [DATA_W-1:0] abs_r;

    always_comb begin
        abs_l = sat_abs(left);
        abs_r = sat_abs(right);
        mag_c = (abs_l > abs_r) ? abs_l : abs_r;
    end

endmodule

// File: rtl/audio_in_level_detector.sv
// Reader side of the codec input FIFO: pops stereo samples with a one-cycle
// strobe, tracks the peak magnitude of each 2**WIN_LOG2-sample window and
// drives a hysteretic sound_detected flag.
// Optional feature: define AUDIO_IN_AVG_EN to add avg_level (window mean magnitude).
// Ports:
//   CLOCK_50, resetn              : clock, async active-low reset
//   enable                        : run; low aborts the current window
//   threshold                     : unsigned detect level, sampled at window end
//   audio_in_available            : FIFO non-empty, sample buses valid
//   left/right_channel_audio_in   : signed samples
//   read_audio_in                 : one-cycle pop strobe
//   peak_level, level_valid       : window peak and its update pulse
//   sound_detected                : hysteretic detect flag
//   avg_level (AUDIO_IN_AVG_EN)   : window mean magnitude
module audio_in_level_detector
    import audio_in_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WIN_LOG2     = 10,
    parameter int unsigned HOLD_WINDOWS = 4
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              enable,
    input  logic [DATA_W-1:0] threshold,
    input  logic              audio_in_available,
    input  logic [DATA_W-1:0] left_channel_audio_in,
    input  logic [DATA_W-1:0] right_channel_audio_in,
    output logic              read_audio_in,
    output logic [DATA_W-1:0] peak_level,
    output logic              level_valid,
    output logic              sound_detected
`ifdef AUDIO_IN_AVG_EN
    ,
    output logic [DATA_W-1:0] avg_level
`endif
);

    localparam int unsigned Q_W   = $clog2(HOLD_WINDOWS + 1);
    localparam int unsigned ACC_W = DATA_W + WIN_LOG2;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0]   l_q;
    logic [DATA_W-1:0]   r_q;
    logic [DATA_W-1:0]   mag_c;
    logic [DATA_W-1:0]   fin_peak_c;
    logic [WIN_LOG2-1:0] sample_cnt;
    logic [DATA_W-1:0]   win_peak;
    logic [Q_W-1:0]      quiet_cnt;

    logic capture_c;
    logic update_c;
    logic last_c;
    logic clear_c;

    audio_in_mag #(.DATA_W(DATA_W)) u_mag (
        .left  (l_q),
        .right (r_q),
        .mag_c (mag_c)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic. IDLE is always revisited between pops, giving a
    // 3-cycle minimum pop spacing so a stale available bit is never re-popped.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (enable && audio_in_available) next_state = POP;
            POP:     next_state = UPDATE;
            UPDATE:  next_state = last_c ? REPORT : IDLE;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decoded control strobes.
    always_comb begin
        capture_c = 1'b0;
        update_c  = 1'b0;
        last_c    = 1'b0;
        clear_c   = 1'b0;
        if (state == POP)
            capture_c = 1'b1;
        if (state == UPDATE && enable)
            update_c = 1'b1;
        if (update_c && (sample_cnt == {WIN_LOG2{1'b1}}))
            last_c = 1'b1;
        // Disabled: abandon the partial window without reporting it.
        if (!enable && (state == IDLE || state == UPDATE))
            clear_c = 1'b1;
    end

    // Peak including the sample being folded in this cycle.
    always_comb begin
        fin_peak_c = (mag_c > win_peak) ? mag_c : win_peak;
    end

    // Datapath, window bookkeeping and detect hysteresis. Window results are
    // written on the UPDATE->REPORT edge so they are visible during REPORT.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            read_audio_in  <= 1'b0;
            level_valid    <= 1'b0;
            peak_level     <= '0;
            sound_detected <= 1'b0;
            l_q            <= '0;
            r_q            <= '0;
            sample_cnt     <= '0;
            win_peak       <= '0;
            quiet_cnt      <= '0;
        end else begin
            read_audio_in <= (next_state == POP);
            level_valid   <= last_c;

            if (capture_c) begin
                l_q <= left_channel_audio_in;
                r_q <= right_channel_audio_in;
            end

            if (clear_c) begin
                sample_cnt <= '0;
                win_peak   <= '0;
            end else if (update_c) begin
                sample_cnt <= sample_cnt + WIN_LOG2'(1);
                if (last_c) begin
                    win_peak   <= '0;
                    peak_level <= fin_peak_c;
                    if (fin_peak_c >= threshold) begin
                        sound_detected <= 1'b1;
                        quiet_cnt      <= '0;
                    end else if (fin_peak_c < (threshold >> 1)) begin
                        if (quiet_cnt + Q_W'(1) >= Q_W'(HOLD_WINDOWS)) begin
                            sound_detected <= 1'b0;
                            quiet_cnt      <= '0;
                        end else begin
                            quiet_cnt <= quiet_cnt + Q_W'(1);
                        end
                    end else begin
                        // Between half-threshold and threshold: hold flag, restart quiet run.
                        quiet_cnt <= '0;
                    end
                end else begin
                    win_peak <= fin_peak_c;
                end
            end
        end
    end

`ifdef AUDIO_IN_AVG_EN
    // Window sum of magnitudes; WIN_LOG2 guard bits make overflow impossible.
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum_c;

    always_comb begin
        acc_sum_c = acc + ACC_W'(mag_c);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            acc       <= '0;
            avg_level <= '0;
        end else if (clear_c) begin
            acc <= '0;
        end else if (update_c) begin
            if (last_c) begin
                acc       <= '0;
                avg_level <= DATA_W'(acc_sum_c >> WIN_LOG2);
            end else begin
                acc <= acc_sum_c;
            end
        end
    end
`endif

endmodule

// File: tb/tb_audio_in_level_detector.sv
// Scoreboard bench for audio_in_level_detector (WIN_LOG2=2, HOLD_WINDOWS=2).
// Stimulus pushes samples into a FIFO model and expected window results into
// a queue; a negedge monitor pops and compares on every level_valid.
module tb_audio_in_level_detector;

    localparam int unsigned DW = 32;
    localparam int unsigned WL = 2;
    localparam int unsigned HW = 2;

    logic          CLOCK_50 = 1'b0;
    logic          resetn   = 1'b1;
    logic          enable   = 1'b0;
    logic [DW-1:0] threshold = 32'd1000;
    logic          audio_in_available = 1'b0;
    logic [DW-1:0] left_channel_audio_in = '0;
    logic [DW-1:0] right_channel_audio_in = '0;
    logic          read_audio_in;
    logic [DW-1:0] peak_level;
    logic          level_valid;
    logic          sound_detected;
`ifdef AUDIO_IN_AVG_EN
    logic [DW-1:0] avg_level;
`endif

    audio_in_level_detector #(
        .DATA_W       (DW),
        .WIN_LOG2     (WL),
        .HOLD_WINDOWS (HW)
    ) dut (
        .CLOCK_50               (CLOCK_50),
        .resetn                 (resetn),
        .enable                 (enable),
        .threshold              (threshold),
        .audio_in_available     (audio_in_available),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .read_audio_in          (read_audio_in),
        .peak_level             (peak_level),
        .level_valid            (level_valid),
        .sound_detected         (sound_detected)
`ifdef AUDIO_IN_AVG_EN
        ,
        .avg_level              (avg_level)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
    } smp_t;

    typedef struct packed {
        logic [31:0] peak;
        logic        sd;
        logic [31:0] avg;
    } exp_t;

    smp_t fifo[$];
    exp_t sb[$];
    int   pop_cyc[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   pop_total = 0;
    int   last_pop  = 0;
    bit   rec_pops  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        smp_t s;
        s.l = l;
        s.r = r;
        fifo.push_back(s);
    endtask

    task automatic expect_win(input logic [31:0] peak, input logic sd, input logic [31:0] avg);
        exp_t e;
        e.peak = peak;
        e.sd   = sd;
        e.avg  = avg;
        sb.push_back(e);
    endtask

    // Window with a single non-zero left sample followed by three zero samples.
    task automatic push_one(input logic [31:0] l);
        push(l, 32'd0);
        repeat (3) push(32'd0, 32'd0);
    endtask

    task automatic wait_drain();
        int i = 0;
        while ((fifo.size() != 0 || sb.size() != 0) && i < 400) begin
            @(posedge CLOCK_50);
            i++;
        end
        check("drain_timeout", 64'(i >= 400), 64'd0);
        repeat (4) @(posedge CLOCK_50);
    endtask

    task automatic wait_pops(input int target);
        int i = 0;
        while (pop_total < target && i < 100) begin
            @(posedge CLOCK_50);
            i++;
        end
        check("pop_wait_timeout", 64'(i >= 100), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_read"}, 64'(read_audio_in), 64'd0);
        check({tag, "_peak"}, 64'(peak_level), 64'd0);
        check({tag, "_valid"}, 64'(level_valid), 64'd0);
        check({tag, "_detect"}, 64'(sound_detected), 64'd0);
`ifdef AUDIO_IN_AVG_EN
        check({tag, "_avg"}, 64'(avg_level), 64'd0);
`endif
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // FIFO model: present the head sample, retire it just after a popping edge.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (read_audio_in && resetn) begin
                @(posedge CLOCK_50);
                #1;
                if (fifo.size() != 0) fifo.delete(0);
            end
            audio_in_available = (fifo.size() != 0);
            if (fifo.size() != 0) begin
                left_channel_audio_in  = fifo[0].l;
                right_channel_audio_in = fifo[0].r;
            end else begin
                left_channel_audio_in  = '0;
                right_channel_audio_in = '0;
            end
        end
    end

    // Monitor: pop tracking and scoreboard comparison on level_valid.
    always @(negedge CLOCK_50) begin
        exp_t e;
        if (read_audio_in) begin
            pop_total++;
            last_pop = cyc;
            if (rec_pops) pop_cyc.push_back(cyc);
        end
        if (level_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_level_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("peak_level", 64'(peak_level), 64'(e.peak));
                check("sound_detected", 64'(sound_detected), 64'(e.sd));
`ifdef AUDIO_IN_AVG_EN
                check("avg_level", 64'(avg_level), 64'(e.avg));
`endif
                check("valid_latency", 64'(cyc - last_pop), 64'd2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        #1 resetn = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_outputs_zero("reset");
        @(negedge CLOCK_50);
        resetn = 1'b1;

        // T1: continuous availability, two windows of zeros.
        rec_pops = 1'b1;
        enable   = 1'b1;
        repeat (8) push(32'd0, 32'd0);
        expect_win(32'd0, 1'b0, 32'd0);
        expect_win(32'd0, 1'b0, 32'd0);
        wait_drain();
        rec_pops = 1'b0;
        check("t1_pop_count", 64'(pop_cyc.size()), 64'd8);
        for (int i = 0; i < 7 && i + 1 < pop_cyc.size(); i++)
            check($sformatf("t1_gap%0d", i), 64'(pop_cyc[i+1] - pop_cyc[i]), (i == 3) ? 64'd4 : 64'd3);

        // T2: peak across channels.
        push(32'd10, 32'd0);
        push(-32'sd2000, 32'd0);
        push(32'd5, -32'sd30);
        push(32'd0, 32'd1500);
        expect_win(32'd2000, 1'b1, 32'd885);
        wait_drain();

        // T3: most-negative sample saturates.
        push_one(32'h8000_0000);
        expect_win(32'h7FFF_FFFF, 1'b1, 32'h1FFF_FFFF);
        wait_drain();

        // T4: hysteresis band and quiet hold.
        push_one(32'd700);
        expect_win(32'd700, 1'b1, 32'd175);
        push_one(32'd400);
        expect_win(32'd400, 1'b1, 32'd100);
        push_one(32'd400);
        expect_win(32'd400, 1'b0, 32'd100);
        push_one(32'd999);
        expect_win(32'd999, 1'b0, 32'd249);
        wait_drain();

        // T5a: disable after two pops discards the partial window.
        base = pop_total;
        push(32'd3000, 32'd0);
        push(32'd0, -32'sd3000);
        wait_pops(base + 2);
        #1 enable = 1'b0;
        repeat (10) @(posedge CLOCK_50);
        check("t5_no_extra_pop", 64'(pop_total), 64'(base + 2));
        enable = 1'b1;
        repeat (4) push(32'd50, 32'd0);
        expect_win(32'd50, 1'b0, 32'd50);
        wait_drain();

        // Arm the detector, then reset mid-window.
        push_one(32'd1200);
        expect_win(32'd1200, 1'b1, 32'd300);
        wait_drain();
        base = pop_total;
        push(32'd5000, 32'd0);
        push(32'd5000, 32'd0);
        wait_pops(base + 2);
        #2 resetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        fifo.delete();
        repeat (2) @(negedge CLOCK_50);
        resetn = 1'b1;
        repeat (10) @(posedge CLOCK_50);
        check("t5_no_pop_after_reset", 64'(pop_total), 64'(base + 2));

        // T6: magnitudes 100..400, mean 250.
        push(32'd100, 32'd0);
        push(32'd0, -32'sd200);
        push(32'd300, 32'd0);
        push(-32'sd400, 32'd0);
        expect_win(32'd400, 1'b0, 32'd250);
        wait_drain();

        // threshold == 0 detects every window.
        threshold = 32'd0;
        repeat (4) push(32'd0, 32'd0);
        expect_win(32'd0, 1'b1, 32'd0);
        wait_drain();

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
